// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file writeback arbiter.
// Each writeback request carries a destination index and write data.
package regfile_pkg;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NREGS = 2 ** AW;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wb_req_t;

    function automatic logic [NREGS-1:0] rd_onehot(input logic [AW-1:0] rd);
        return NREGS'(1) << rd;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small per-source writeback queue with registered occupancy count.
// Exposes per-entry valid bits and destination indices for hazard masking.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  wb_req_t                  din_i,
    output logic                     full_o,
    output logic                     empty_o,
    output wb_req_t                  head_o,
    output logic [DEPTH-1:0]         vld_o,
    output logic [DEPTH-1:0][AW-1:0] rd_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_req_t          mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [DEPTH-1:0] vld_q,    vld_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign vld_o   = vld_q;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        vld_d    = vld_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        // Push and pop never target the same slot: pop needs an entry, push needs a hole.
        if (do_push) begin
            wr_ptr_d         = wr_ptr_q + PW'(1);
            vld_d[wr_ptr_q]  = 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d         = rd_ptr_q + PW'(1);
            vld_d[rd_ptr_q]  = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rd_o[i] = mem_q[i].rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port between the ALU (A)
// and load unit (B) writeback queues; also exports the pending-write mask.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [AW-1:0]    a_rd,
    input  logic [DW-1:0]    a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [AW-1:0]    b_rd,
    input  logic [DW-1:0]    b_data,
    output logic             rf_we,
    output logic [AW-1:0]    rf_rd,
    output logic [DW-1:0]    rf_indata,
    output logic [NREGS-1:0] pending_mask
);

    logic                     a_full, a_empty, b_full, b_empty;
    logic                     a_push, b_push, pop_a, pop_b;
    wb_req_t                  a_head, b_head;
    logic [DEPTH-1:0]         a_vld, b_vld;
    logic [DEPTH-1:0][AW-1:0] a_rds, b_rds;

    logic          rr_q, rr_d;
    logic          rf_we_q, rf_we_d;
    logic [AW-1:0] rf_rd_q, rf_rd_d;
    logic [DW-1:0] rf_indata_q, rf_indata_d;

    assign a_ready = !a_full;
    assign b_ready = !b_full;

    // Writes to r0 complete the handshake but are never queued.
    assign a_push = a_valid && a_ready && (a_rd != '0);
    assign b_push = b_valid && b_ready && (b_rd != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk     (clk),
        .rst     (rst),
        .push_i  (a_push),
        .pop_i   (pop_a),
        .din_i   ('{rd: a_rd, data: a_data}),
        .full_o  (a_full),
        .empty_o (a_empty),
        .head_o  (a_head),
        .vld_o   (a_vld),
        .rd_o    (a_rds)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk     (clk),
        .rst     (rst),
        .push_i  (b_push),
        .pop_i   (pop_b),
        .din_i   ('{rd: b_rd, data: b_data}),
        .full_o  (b_full),
        .empty_o (b_empty),
        .head_o  (b_head),
        .vld_o   (b_vld),
        .rd_o    (b_rds)
    );

    // rr_q names the source that wins the next contended cycle; it only moves on contention.
    always_comb begin
        pop_a       = 1'b0;
        pop_b       = 1'b0;
        rr_d        = rr_q;
        rf_rd_d     = rf_rd_q;
        rf_indata_d = rf_indata_q;
        if (!a_empty && !b_empty) begin
            if (rr_q == SRC_A) pop_a = 1'b1;
            else               pop_b = 1'b1;
            rr_d = (rr_q == SRC_A) ? SRC_B : SRC_A;
        end else if (!a_empty) begin
            pop_a = 1'b1;
        end else if (!b_empty) begin
            pop_b = 1'b1;
        end
        rf_we_d = pop_a || pop_b;
        if (pop_a) begin
            rf_rd_d     = a_head.rd;
            rf_indata_d = a_head.data;
        end else if (pop_b) begin
            rf_rd_d     = b_head.rd;
            rf_indata_d = b_head.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q        <= SRC_A;
            rf_we_q     <= 1'b0;
            rf_rd_q     <= '0;
            rf_indata_q <= '0;
        end else begin
            rr_q        <= rr_d;
            rf_we_q     <= rf_we_d;
            rf_rd_q     <= rf_rd_d;
            rf_indata_q <= rf_indata_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_rd     = rf_rd_q;
    assign rf_indata = rf_indata_q;

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (a_vld[i]) pending_mask = pending_mask | rd_onehot(a_rds[i]);
            if (b_vld[i]) pending_mask = pending_mask | rd_onehot(b_rds[i]);
        end
        if (rf_we_q) pending_mask = pending_mask | rd_onehot(rf_rd_q);
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected port writes are queued as
// stimulus is issued, and a monitor compares each rf_we cycle against the queue.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             a_valid, b_valid;
    logic             a_ready, b_ready;
    logic [AW-1:0]    a_rd, b_rd;
    logic [DW-1:0]    a_data, b_data;
    logic             rf_we;
    logic [AW-1:0]    rf_rd;
    logic [DW-1:0]    rf_indata;
    logic [NREGS-1:0] pending_mask;

    int total = 0;
    int bad   = 0;

    wb_req_t       exp_q[$];
    logic [AW-1:0] a_rd_v [8];
    logic [DW-1:0] a_dat_v[8];
    logic [AW-1:0] b_rd_v [8];
    logic [DW-1:0] b_dat_v[8];

    regfile_wb_arbiter #(.DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_rd         (a_rd),
        .a_data       (a_data),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_rd         (b_rd),
        .b_data       (b_data),
        .rf_we        (rf_we),
        .rf_rd        (rf_rd),
        .rf_indata    (rf_indata),
        .pending_mask (pending_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Monitor: every port write must match the head of the expected queue.
    initial begin : monitor
        wb_req_t e;
        forever begin
            @(negedge clk);
            if (rf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got rd=%0d data=%h, want no write", rf_rd, rf_indata);
                end else begin
                    e = exp_q.pop_front();
                    chk("port_rd", 64'(rf_rd), 64'(e.rd));
                    chk("port_data", 64'(rf_indata), 64'(e.data));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic expect_wr(input logic [AW-1:0] rd, input logic [DW-1:0] data);
        exp_q.push_back('{rd: rd, data: data});
    endtask

    // Drive both sources from the item tables, holding an item until accepted.
    // At cycle chk_cyc (sampled 1 time unit after the preceding edge) check mask and a_ready.
    task automatic run_streams(input int na, input int a_off, input int nb, input int b_off,
                               input int chk_cyc, input logic [NREGS-1:0] chk_mask,
                               input logic chk_ardy);
        int  ia  = 0;
        int  ib  = 0;
        int  cyc = 0;
        logic acc_a, acc_b;
        while ((ia < na || ib < nb) && cyc < 40) begin
            if (cyc == chk_cyc) begin
                chk("stream_mask", 64'(pending_mask), 64'(chk_mask));
                chk("stream_a_ready", 64'(a_ready), 64'(chk_ardy));
            end
            a_valid = (ia < na) && (cyc >= a_off);
            a_rd    = (ia < na) ? a_rd_v[ia]  : '0;
            a_data  = (ia < na) ? a_dat_v[ia] : '0;
            b_valid = (ib < nb) && (cyc >= b_off);
            b_rd    = (ib < nb) ? b_rd_v[ib]  : '0;
            b_data  = (ib < nb) ? b_dat_v[ib] : '0;
            acc_a   = a_valid && a_ready;
            acc_b   = b_valid && b_ready;
            @(posedge clk);
            #1;
            if (acc_a) ia++;
            if (acc_b) ib++;
            cyc++;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        chk("streams_accepted", 64'(ia + ib), 64'(na + nb));
    endtask

    task automatic drain(input string name);
        idle(12);
        chk(name, 64'(exp_q.size()), 64'd0);
        chk("idle_mask", 64'(pending_mask), 64'd0);
    endtask

    initial begin
        rst     = 1'b1;
        a_valid = 1'b1;
        a_rd    = 5'd7;
        a_data  = 32'hCAFE_0007;
        b_valid = 1'b0;
        b_rd    = '0;
        b_data  = '0;

        // Reset held for two cycles with A requesting.
        @(posedge clk); #1;
        chk("rst_we_1", 64'(rf_we), 64'd0);
        chk("rst_mask_1", 64'(pending_mask), 64'd0);
        @(posedge clk); #1;
        chk("rst_we_2", 64'(rf_we), 64'd0);
        chk("rst_mask_2", 64'(pending_mask), 64'd0);
        chk("rst_rd", 64'(rf_rd), 64'd0);
        chk("rst_data", 64'(rf_indata), 64'd0);
        rst     = 1'b0;
        a_valid = 1'b0;
        chk("rst_a_ready", 64'(a_ready), 64'd1);
        chk("rst_b_ready", 64'(b_ready), 64'd1);
        idle(3);
        chk("rst_no_queue", 64'(pending_mask), 64'd0);

        // Single write with latency checks.
        expect_wr(5'd5, 32'hDEAD_BEEF);
        a_valid = 1'b1;
        a_rd    = 5'd5;
        a_data  = 32'hDEAD_BEEF;
        chk("single_a_ready", 64'(a_ready), 64'd1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        chk("single_mask_e0", 64'(pending_mask), 64'h20);
        chk("single_we_e0", 64'(rf_we), 64'd0);
        @(posedge clk); #1;
        chk("single_we_e1", 64'(rf_we), 64'd1);
        chk("single_rd_e1", 64'(rf_rd), 64'd5);
        chk("single_data_e1", 64'(rf_indata), 64'hDEAD_BEEF);
        chk("single_mask_e1", 64'(pending_mask), 64'h20);
        @(posedge clk); #1;
        chk("single_we_e2", 64'(rf_we), 64'd0);
        chk("single_mask_e2", 64'(pending_mask), 64'd0);
        drain("single_drain");

        // Contention: alternate A/B starting with A.
        do_reset();
        a_rd_v[0] = 5'd1;  a_dat_v[0] = 32'hA000_0001;
        a_rd_v[1] = 5'd2;  a_dat_v[1] = 32'hA000_0002;
        a_rd_v[2] = 5'd3;  a_dat_v[2] = 32'hA000_0003;
        b_rd_v[0] = 5'd9;  b_dat_v[0] = 32'hB000_0009;
        b_rd_v[1] = 5'd10; b_dat_v[1] = 32'hB000_000A;
        b_rd_v[2] = 5'd11; b_dat_v[2] = 32'hB000_000B;
        expect_wr(5'd1,  32'hA000_0001);
        expect_wr(5'd9,  32'hB000_0009);
        expect_wr(5'd2,  32'hA000_0002);
        expect_wr(5'd10, 32'hB000_000A);
        expect_wr(5'd3,  32'hA000_0003);
        expect_wr(5'd11, 32'hB000_000B);
        run_streams(3, 0, 3, 0, 2, 32'h0000_0606, 1'b1);
        drain("contention_drain");

        // Backpressure: A full in cycle 4 while it pops; held item written later.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a_rd_v[i]  = 5'(20 + i);
            a_dat_v[i] = 32'h5A00_0000 + 32'(i);
            b_rd_v[i]  = 5'(12 + i);
            b_dat_v[i] = 32'h4B00_0000 + 32'(i);
        end
        expect_wr(5'd12, 32'h4B00_0000);
        expect_wr(5'd20, 32'h5A00_0000);
        expect_wr(5'd13, 32'h4B00_0001);
        expect_wr(5'd21, 32'h5A00_0001);
        expect_wr(5'd14, 32'h4B00_0002);
        expect_wr(5'd22, 32'h5A00_0002);
        expect_wr(5'd15, 32'h4B00_0003);
        expect_wr(5'd23, 32'h5A00_0003);
        run_streams(4, 1, 4, 0, 4, 32'h0060_6000, 1'b0);
        drain("backpressure_drain");

        // r0 write: accepted, never reaches the port or the mask.
        do_reset();
        b_rd_v[0]  = 5'd0;
        b_dat_v[0] = 32'h0000_1234;
        run_streams(0, 0, 1, 0, 0, 32'h0, 1'b1);
        chk("r0_mask_e0", 64'(pending_mask), 64'd0);
        idle(1);
        chk("r0_we_e1", 64'(rf_we), 64'd0);
        chk("r0_mask_e1", 64'(pending_mask), 64'd0);
        drain("r0_drain");

        // Reset mid-operation discards everything still queued.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            a_rd_v[i]  = 5'(24 + i);
            a_dat_v[i] = 32'h6600_0000 + 32'(i);
            b_rd_v[i]  = 5'(16 + i);
            b_dat_v[i] = 32'h7700_0000 + 32'(i);
        end
        expect_wr(5'd24, 32'h6600_0000);
        expect_wr(5'd16, 32'h7700_0000);
        expect_wr(5'd25, 32'h6600_0001);
        run_streams(3, 0, 3, 0, 3, 32'h0603_0000, 1'b0);
        chk("midrst_we_before", 64'(rf_we), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_we_after", 64'(rf_we), 64'd0);
        chk("midrst_mask_after", 64'(pending_mask), 64'd0);
        chk("midrst_a_ready", 64'(a_ready), 64'd1);
        chk("midrst_b_ready", 64'(b_ready), 64'd1);
        drain("midrst_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
